mem_bus_arbiter: RTL and testbench

//  Two-requester round-robin arbiter sharing the single Mem_top port (addr/data/req_valid/data_valid/WE bus).

---
 rtl/mem_bus_arbiter_pkg.sv | 14 +
 rtl/mem_bus_arbiter_rr.sv | 21 ++
 rtl/mem_bus_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-requester memory bus arbiter:
// transaction FSM encoding and requester identifiers.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_rr.sv
// Combinational two-way round-robin winner select: the requester named by
// rr_ptr wins if it is requesting, otherwise the other one does.
module rr_arbiter2
  import mem_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic       any_req,
  output logic       winner
);

  always_comb begin
    any_req = |req;
    if (rr_ptr == M0) begin
      winner = req[0] ? M0 : M1;
    end else begin
      winner = req[1] ? M1 : M0;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Serialises m0/m1 transactions onto the single Mem_top port, one at a time,
// with round-robin ownership and a watchdog that aborts unanswered requests.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter  int MEM_DEPTH  = 8,
  parameter  int DATA_WIDTH = 32,
  parameter  int TIMEOUT    = 15,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req_valid,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_done,
  output logic                  m0_err,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req_valid,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_done,
  output logic                  m1_err,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  mem_req_valid,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_data_valid,
  output logic                  grant_id
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t                state_reg, state_next;
  logic                  rr_ptr_reg, rr_ptr_next;
  logic [TW-1:0]         timer_reg, timer_next;
  logic                  grant_reg, grant_next;
  logic                  mem_req_reg, mem_req_next;
  logic                  mem_we_reg, mem_we_next;
  logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_WIDTH-1:0] mem_wdata_reg, mem_wdata_next;
  logic [1:0]            done_reg, done_next;
  logic [1:0]            err_reg, err_next;
  logic [1:0]            rdata_load;
  logic [DATA_WIDTH-1:0] rdata_reg [2];

  logic any_req;
  logic winner;

  rr_arbiter2 u_rr (
    .req     ({m1_req_valid, m0_req_valid}),
    .rr_ptr  (rr_ptr_reg),
    .any_req (any_req),
    .winner  (winner)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      rr_ptr_reg    <= M0;
      timer_reg     <= '0;
      grant_reg     <= M0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      done_reg      <= '0;
      err_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      timer_reg     <= timer_next;
      grant_reg     <= grant_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
    end
  end

  // Read data is per requester and survives until that requester's next read.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rdata_reg[gi] <= '0;
      end else if (rdata_load[gi]) begin
        rdata_reg[gi] <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    timer_next     = timer_reg;
    grant_next     = grant_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    done_next      = '0;
    err_next       = '0;
    rdata_load     = '0;
    case (state_reg)
      ST_IDLE: begin
        if (any_req) begin
          grant_next     = winner;
          mem_we_next    = (winner == M1) ? m1_we    : m0_we;
          mem_addr_next  = (winner == M1) ? m1_addr  : m0_addr;
          mem_wdata_next = (winner == M1) ? m1_wdata : m0_wdata;
          mem_req_next   = 1'b1;
          timer_next     = '0;
          state_next     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // An ack arriving on the last allowed cycle still counts as success.
        if (mem_data_valid) begin
          mem_req_next          = 1'b0;
          done_next[grant_reg]  = 1'b1;
          rdata_load[grant_reg] = ~mem_we_reg;
          state_next            = ST_DONE;
        end else if (timer_reg == TW'(TIMEOUT - 1)) begin
          mem_req_next         = 1'b0;
          done_next[grant_reg] = 1'b1;
          err_next[grant_reg]  = 1'b1;
          state_next           = ST_DONE;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      ST_DONE: begin
        // One dead cycle lets the finished requester drop req_valid before re-arbitration.
        rr_ptr_next = ~grant_reg;
        state_next  = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign m0_done       = done_reg[0];
  assign m1_done       = done_reg[1];
  assign m0_err        = err_reg[0];
  assign m1_err        = err_reg[1];
  assign m0_rdata      = rdata_reg[0];
  assign m1_rdata      = rdata_reg[1];
  assign mem_req_valid = mem_req_reg;
  assign mem_we        = mem_we_reg;
  assign mem_addr      = mem_addr_reg;
  assign mem_wdata     = mem_wdata_reg;
  assign grant_id      = grant_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomised and directed bench for mem_bus_arbiter: a transaction-level
// reference model is compared against the DUT every cycle.
module tb_mem_bus_arbiter;

  localparam int AW = 3;
  localparam int DW = 32;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req_valid, m0_we, m1_req_valid, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_done, m0_err, m1_done, m1_err;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_req_valid, mem_we, mem_data_valid, grant_id;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_bus_arbiter #(.MEM_DEPTH(8), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_req_valid(m0_req_valid), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req_valid(m1_req_valid), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_req_valid(mem_req_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid),
    .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- stimulus agents ----------------
  bit          auto_en = 0;
  int          mem_mode = 1;     // 0 random, 1 fixed delay, 2 never ack
  int          ack_delay = 0;
  bit          fix_en = 0;
  logic [31:0] fix_data = '0;
  int          busy_cnt = 0;
  int          cur_delay = 0;

  always @(posedge clk) begin
    #1;
    if (m0_done) m0_req_valid = 1'b0;
    else if (auto_en && !m0_req_valid && $urandom_range(3) == 0) begin
      m0_req_valid = 1'b1; m0_we = 1'($urandom_range(1));
      m0_addr = AW'($urandom_range(7)); m0_wdata = $urandom;
    end else if (auto_en && m0_req_valid && $urandom_range(63) == 0) m0_req_valid = 1'b0;
    if (m1_done) m1_req_valid = 1'b0;
    else if (auto_en && !m1_req_valid && $urandom_range(3) == 0) begin
      m1_req_valid = 1'b1; m1_we = 1'($urandom_range(1));
      m1_addr = AW'($urandom_range(7)); m1_wdata = $urandom;
    end else if (auto_en && m1_req_valid && $urandom_range(63) == 0) m1_req_valid = 1'b0;

    mem_rdata = fix_en ? fix_data : $urandom;
    if (mem_req_valid) begin
      if (busy_cnt == 0)
        cur_delay = (mem_mode == 1) ? ack_delay : (mem_mode == 2) ? 1000 :
                    (($urandom_range(15) == 0) ? 1000 : int'($urandom_range(5)));
      mem_data_valid = (busy_cnt == cur_delay);
      busy_cnt++;
    end else begin
      busy_cnt = 0;
      mem_data_valid = (mem_mode == 0) && ($urandom_range(3) == 0);
    end
  end

  // ---------------- reference model ----------------
  // A transaction is granted, occupies the memory port until ack or its
  // TO-th cycle, reports completion the next cycle, then one cycle passes
  // before anyone new may be granted. Fairness: the turn passes to the other
  // requester after every completion.
  bit          exp_mreq, exp_we, exp_grant;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;
  bit [1:0]    exp_done, exp_err;
  logic [DW-1:0] exp_rdata [2];
  bit          txn_open, reporting, turn;
  int          age;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_mreq = 0; exp_we = 0; exp_grant = 0; exp_addr = '0; exp_wdata = '0;
      exp_done = '0; exp_err = '0; exp_rdata[0] = '0; exp_rdata[1] = '0;
      txn_open = 0; reporting = 0; turn = 0; age = 0;
    end else begin
      exp_done = '0;
      exp_err  = '0;
      if (reporting) begin
        reporting = 0;
        turn = !exp_grant;
      end else if (txn_open) begin
        age++;
        if (mem_data_valid || age == TO) begin
          txn_open = 0; exp_mreq = 0; reporting = 1;
          exp_done[exp_grant] = 1'b1;
          exp_err[exp_grant]  = !mem_data_valid;
          if (mem_data_valid && !exp_we) exp_rdata[exp_grant] = mem_rdata;
        end
      end else if (m0_req_valid || m1_req_valid) begin
        if (turn) exp_grant = m1_req_valid ? 1'b1 : 1'b0;
        else      exp_grant = m0_req_valid ? 1'b0 : 1'b1;
        exp_we    = exp_grant ? m1_we    : m0_we;
        exp_addr  = exp_grant ? m1_addr  : m0_addr;
        exp_wdata = exp_grant ? m1_wdata : m0_wdata;
        exp_mreq  = 1; txn_open = 1; age = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("mem_req_valid", 32'(mem_req_valid), 32'(exp_mreq));
    chk("grant_id", 32'(grant_id), 32'(exp_grant));
    chk("m0_done", 32'(m0_done), 32'(exp_done[0]));
    chk("m1_done", 32'(m1_done), 32'(exp_done[1]));
    chk("m0_rdata", m0_rdata, exp_rdata[0]);
    chk("m1_rdata", m1_rdata, exp_rdata[1]);
    if (exp_done[0]) chk("m0_err", 32'(m0_err), 32'(exp_err[0]));
    if (exp_done[1]) chk("m1_err", 32'(m1_err), 32'(exp_err[1]));
    if (exp_mreq) begin
      chk("mem_we", 32'(mem_we), 32'(exp_we));
      chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
      chk("mem_wdata", mem_wdata, exp_wdata);
    end
  end

  // ---------------- directed sequence ----------------
  task automatic wait_done(input string name);
    int n = 0;
    while (!(m0_done || m1_done) && n < 60) begin
      tick(1);
      n++;
    end
    if (!(m0_done || m1_done)) begin
      checks++;
      $display("FAIL %s: done never arrived within 60 cycles", name);
    end
  endtask

  initial begin
    int  cnt;
    bit  seen;
    bit  g;
    reset = 1'b0;
    m0_req_valid = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req_valid = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    mem_rdata = '0; mem_data_valid = 0;
    tick(3);
    chk("rst_mem_req_valid", 32'(mem_req_valid), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_done", 32'({m1_done, m0_done}), 0);
    reset = 1'b1;
    tick(2);

    // single read, ack on third busy cycle
    mem_mode = 1; ack_delay = 2; fix_en = 1; fix_data = 32'hDEADBEEF;
    m0_req_valid = 1; m0_we = 0; m0_addr = 3'd3;
    tick(1);
    chk("rd_latency_req", 32'(mem_req_valid), 1);
    chk("rd_mem_addr", 32'(mem_addr), 3);
    wait_done("rd_done");
    chk("rd_m0_done", 32'(m0_done), 1);
    chk("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
    chk("rd_m0_err", 32'(m0_err), 0);
    chk("rd_m1_done", 32'(m1_done), 0);
    tick(2);

    // write from m1
    ack_delay = 1;
    m1_req_valid = 1; m1_we = 1; m1_addr = 3'd5; m1_wdata = 32'h12345678;
    tick(1);
    chk("wr_mem_we", 32'(mem_we), 1);
    chk("wr_mem_addr", 32'(mem_addr), 5);
    chk("wr_mem_wdata", mem_wdata, 32'h12345678);
    wait_done("wr_done");
    chk("wr_m1_done", 32'(m1_done), 1);
    chk("wr_m1_err", 32'(m1_err), 0);
    chk("wr_m1_rdata_kept", m1_rdata, 0);
    tick(2);

    // contention straight after reset: strict alternation
    reset = 1'b0; tick(1); reset = 1'b1;
    ack_delay = 0; fix_en = 0;
    m0_req_valid = 1; m0_we = 0; m0_addr = 3'd1;
    m1_req_valid = 1; m1_we = 1; m1_addr = 3'd2; m1_wdata = 32'hA5A5A5A5;
    for (int i = 0; i < 4; i++) begin
      wait_done("rr_done");
      g = m1_done;
      chk("rr_order", 32'(g), 32'(i % 2));
      chk("rr_grant_id", 32'(grant_id), 32'(i % 2));
      tick(1);
      if (i < 3) begin
        if (g) m1_req_valid = 1; else m0_req_valid = 1;
      end
    end
    wait_done("rr_drain");
    chk("rr_drain_owner", 32'(grant_id), 0);
    tick(2);

    // timeout: memory never answers
    mem_mode = 2;
    m0_req_valid = 1; m0_we = 0; m0_addr = 3'd4;
    cnt = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick(1);
      if (mem_req_valid) cnt++;
      if (m0_done) seen = 1;
    end
    chk("to_seen_done", 32'(seen), 1);
    chk("to_busy_cycles", cnt, TO);
    chk("to_m0_err", 32'(m0_err), 1);
    chk("to_mem_req_valid", 32'(mem_req_valid), 0);
    tick(2);
    mem_mode = 1; ack_delay = 3;
    m0_req_valid = 1; m0_we = 1; m0_addr = 3'd7; m0_wdata = 32'h0BADF00D;
    wait_done("to_next_done");
    chk("to_next_err", 32'(m0_err), 0);
    tick(2);

    // ack lands on the final allowed busy cycle
    ack_delay = TO - 1; fix_en = 1; fix_data = 32'hCAFEF00D;
    m1_req_valid = 1; m1_we = 0; m1_addr = 3'd6;
    wait_done("edge_done");
    chk("edge_m1_err", 32'(m1_err), 0);
    chk("edge_m1_rdata", m1_rdata, 32'hCAFEF00D);
    tick(2);

    // async reset mid-transaction
    mem_mode = 2; fix_en = 0;
    m0_req_valid = 1; m0_we = 1; m0_addr = 3'd6; m0_wdata = 32'h55AA55AA;
    tick(3);
    #2 reset = 1'b0;
    #1;
    chk("arst_mem_req_valid", 32'(mem_req_valid), 0);
    chk("arst_mem_addr", 32'(mem_addr), 0);
    chk("arst_m0_done", 32'(m0_done), 0);
    tick(1);
    m0_req_valid = 0;
    m1_req_valid = 1; m1_we = 0; m1_addr = 3'd2;
    mem_mode = 1; ack_delay = 1;
    reset = 1'b1;
    wait_done("arst_next_done");
    chk("arst_next_m1_done", 32'(m1_done), 1);
    chk("arst_next_grant", 32'(grant_id), 1);
    tick(2);

    // randomised traffic
    mem_mode = 0; auto_en = 1;
    tick(3000);
    auto_en = 0; mem_mode = 1; ack_delay = 0;
    tick(60);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
